alu_share_arbiter: RTL and testbench

Sequencer that shares the single combinational integer ALU between several requesters, for example the main issue stage and the branch-compare unit. It accepts one operation per transaction through a valid/ready handshake and picks among competing requesters round-robin. It drives registered operands and op code into the ALU, captures result/overflow/write-enable one cycle later, and holds the response until the owning requester accepts it. Sits between the requesters and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_share_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one combinational ALU among N_REQ requesters.
// Flow per operation: accept (IDLE), evaluate (EXEC), hold response until the owner takes it (RESP).
module alu_share_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [32*N_REQ-1:0]  i_req_opr1,
    input  logic [32*N_REQ-1:0]  i_req_opr2,
    input  logic [5*N_REQ-1:0]   i_req_op,
    output logic [N_REQ-1:0]     o_req_ready,
    output logic [31:0]          o_alu_opr1,
    output logic [31:0]          o_alu_opr2,
    output logic [4:0]           o_alu_op,
    input  logic [31:0]          i_alu_result,
    input  logic                 i_alu_overflow,
    input  logic                 i_alu_no_write_override,
    output logic [N_REQ-1:0]     o_rsp_valid,
    output logic [31:0]          o_rsp_result,
    output logic                 o_rsp_overflow,
    output logic                 o_rsp_write_en,
    output logic [ID_W-1:0]      o_rsp_id,
    input  logic [N_REQ-1:0]     i_rsp_ready,
    output logic                 o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [ID_W-1:0]    rr_ptr_r, owner_r, grant_idx_s, rr_next_s;
    logic               grant_found_s, accept_s, owner_rsp_ready_s;
    logic [31:0]        alu_opr1_r, alu_opr2_r, sel_opr1_s, sel_opr2_s;
    logic [4:0]         alu_op_r, sel_op_s;
    logic [31:0]        rsp_result_r;
    logic               rsp_overflow_r, rsp_write_en_r;
    logic [N_REQ-1:0]   req_ready_s, rsp_valid_s;

    // Round-robin scan: first valid requester at or after rr_ptr, wrapping modulo N_REQ
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!grant_found_s && (k == (int'(rr_ptr_r) + i) % N_REQ) && i_req_valid[k]) begin
                    grant_found_s = 1'b1;
                    grant_idx_s   = ID_W'(k);
                end
            end
        end
        if (grant_idx_s == ID_W'(N_REQ - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_idx_s + ID_W'(1);
        end
    end

    // Operand mux, one-hot accept, one-hot response valid and owner's response-ready
    always_comb begin
        sel_opr1_s        = 32'd0;
        sel_opr2_s        = 32'd0;
        sel_op_s          = 5'd0;
        req_ready_s       = '0;
        rsp_valid_s       = '0;
        owner_rsp_ready_s = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_idx_s == ID_W'(k)) begin
                sel_opr1_s = i_req_opr1[32*k +: 32];
                sel_opr2_s = i_req_opr2[32*k +: 32];
                sel_op_s   = i_req_op[5*k +: 5];
            end
            if (owner_r == ID_W'(k)) begin
                owner_rsp_ready_s = i_rsp_ready[k];
            end
            // Ready is suppressed during reset so nothing is offered in a cycle that cannot commit
            req_ready_s[k] = (state_r == ST_IDLE) && !i_rst && grant_found_s && (grant_idx_s == ID_W'(k));
            rsp_valid_s[k] = (state_r == ST_RESP) && (owner_r == ID_W'(k));
        end
    end

    // Next-state logic
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_found_s) begin
                    accept_s = 1'b1;
                    state_s  = ST_EXEC;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_EXEC: state_s = ST_RESP;
            ST_RESP: begin
                if (owner_rsp_ready_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, operand and response registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r        <= ST_IDLE;
            rr_ptr_r       <= '0;
            owner_r        <= '0;
            alu_opr1_r     <= 32'd0;
            alu_opr2_r     <= 32'd0;
            alu_op_r       <= 5'd0;
            rsp_result_r   <= 32'd0;
            rsp_overflow_r <= 1'b0;
            rsp_write_en_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                alu_opr1_r <= sel_opr1_s;
                alu_opr2_r <= sel_opr2_s;
                alu_op_r   <= sel_op_s;
                owner_r    <= grant_idx_s;
                rr_ptr_r   <= rr_next_s;
            end
            // ALU flags are copied verbatim; the arbiter never derives write permission itself
            if (state_r == ST_EXEC) begin
                rsp_result_r   <= i_alu_result;
                rsp_overflow_r <= i_alu_overflow;
                rsp_write_en_r <= i_alu_no_write_override;
            end
        end
    end

    assign o_req_ready    = req_ready_s;
    assign o_alu_opr1     = alu_opr1_r;
    assign o_alu_opr2     = alu_opr2_r;
    assign o_alu_op       = alu_op_r;
    assign o_rsp_valid    = rsp_valid_s;
    assign o_rsp_result   = rsp_result_r;
    assign o_rsp_overflow = rsp_overflow_r;
    assign o_rsp_write_en = rsp_write_en_r;
    assign o_rsp_id       = owner_r;
    assign o_busy         = (state_r != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: ALU stand-in, transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_alu_share_arbiter;

    localparam int N  = 3;
    localparam int IW = 3;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDU = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SUBU = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4;
    localparam logic [4:0] OP_OR   = 5'd5;
    localparam logic [4:0] OP_XOR  = 5'd6;
    localparam logic [4:0] OP_SLT  = 5'd7;
    localparam logic [4:0] OP_SLTU = 5'd8;
    localparam logic [4:0] OP_MOVZ = 5'd9;
    localparam logic [4:0] OP_MOVN = 5'd10;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [N-1:0]     i_req_valid;
    logic [32*N-1:0]  i_req_opr1, i_req_opr2;
    logic [5*N-1:0]   i_req_op;
    logic [N-1:0]     o_req_ready;
    logic [31:0]      o_alu_opr1, o_alu_opr2;
    logic [4:0]       o_alu_op;
    logic [31:0]      i_alu_result;
    logic             i_alu_overflow, i_alu_no_write_override;
    logic [N-1:0]     o_rsp_valid;
    logic [31:0]      o_rsp_result;
    logic             o_rsp_overflow, o_rsp_write_en;
    logic [IW-1:0]    o_rsp_id;
    logic [N-1:0]     i_rsp_ready;
    logic             o_busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_share_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .i_req_opr1(i_req_opr1), .i_req_opr2(i_req_opr2), .i_req_op(i_req_op),
        .o_req_ready(o_req_ready),
        .o_alu_opr1(o_alu_opr1), .o_alu_opr2(o_alu_opr2), .o_alu_op(o_alu_op),
        .i_alu_result(i_alu_result), .i_alu_overflow(i_alu_overflow),
        .i_alu_no_write_override(i_alu_no_write_override),
        .o_rsp_valid(o_rsp_valid), .o_rsp_result(o_rsp_result), .o_rsp_overflow(o_rsp_overflow),
        .o_rsp_write_en(o_rsp_write_en), .o_rsp_id(o_rsp_id),
        .i_rsp_ready(i_rsp_ready), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Reference ALU: {result, overflow, write permit}
    function automatic logic [33:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        ov, we;
        r = 32'hcdcdcdcd; ov = 1'b0; we = 1'b1;
        case (op)
            OP_ADD:  begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); we = !ov; end
            OP_ADDU: r = a + b;
            OP_SUB:  begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); we = !ov; end
            OP_SUBU: r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            OP_MOVZ: begin r = a; we = (b == 32'd0); end
            OP_MOVN: begin r = a; we = (b != 32'd0); end
            default: ;
        endcase
        return {r, ov, we};
    endfunction

    always_comb {i_alu_result, i_alu_overflow, i_alu_no_write_override} = alu_fn(o_alu_op, o_alu_opr1, o_alu_opr2);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: tracks the transaction in flight and checks every output each cycle
    initial begin : model
        int          ph, rr, own, g;
        logic [31:0] ma1, ma2, mres, pres;
        logic [4:0]  mop;
        logic        mov, mwe, pov, pwe, live;
        logic [N-1:0] er, ev;
        ph = 0; rr = 0; own = 0; ma1 = 32'd0; ma2 = 32'd0; mop = 5'd0;
        mres = 32'd0; mov = 1'b0; mwe = 1'b0; pres = 32'd0; pov = 1'b0; pwe = 1'b0; live = 1'b0;
        forever begin
            @(negedge i_clk);
            g = -1;
            if (!i_rst && ph == 0) begin
                for (int i = 0; i < N; i++) begin
                    if (g < 0 && ((i_req_valid >> ((rr + i) % N)) & N'(1)) != '0) g = (rr + i) % N;
                end
            end
            er = (g >= 0) ? (N'(1) << g) : '0;
            ev = (ph == 2) ? (N'(1) << own) : '0;
            if (live) begin
                check("m_req_ready",  64'(o_req_ready),    64'(er));
                check("m_busy",       64'(o_busy),         64'(ph != 0));
                check("m_rsp_valid",  64'(o_rsp_valid),    64'(ev));
                check("m_rsp_id",     64'(o_rsp_id),       64'(own));
                check("m_rsp_result", 64'(o_rsp_result),   64'(mres));
                check("m_rsp_ovf",    64'(o_rsp_overflow), 64'(mov));
                check("m_rsp_we",     64'(o_rsp_write_en), 64'(mwe));
                check("m_alu_opr1",   64'(o_alu_opr1),     64'(ma1));
                check("m_alu_opr2",   64'(o_alu_opr2),     64'(ma2));
                check("m_alu_op",     64'(o_alu_op),       64'(mop));
            end
            if (i_rst) begin
                ph = 0; rr = 0; own = 0; ma1 = 32'd0; ma2 = 32'd0; mop = 5'd0;
                mres = 32'd0; mov = 1'b0; mwe = 1'b0; live = 1'b1;
            end else begin
                case (ph)
                    0: if (g >= 0) begin
                        ma1 = 32'(i_req_opr1 >> (32 * g));
                        ma2 = 32'(i_req_opr2 >> (32 * g));
                        mop = 5'(i_req_op >> (5 * g));
                        own = g;
                        rr  = (g + 1) % N;
                        {pres, pov, pwe} = alu_fn(mop, ma1, ma2);
                        ph  = 1;
                    end
                    1: begin mres = pres; mov = pov; mwe = pwe; ph = 2; end
                    2: if (((i_rsp_ready >> own) & N'(1)) != '0) ph = 0;
                    default: ph = 0;
                endcase
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        i_req_opr1[32*k +: 32] = a;
        i_req_opr2[32*k +: 32] = b;
        i_req_op[5*k +: 5]     = op;
        i_req_valid            = i_req_valid | (N'(1) << k);
    endtask

    task automatic clr_req(input int k);
        i_req_valid = i_req_valid & ~(N'(1) << k);
    endtask

    // One isolated transaction with i_rsp_ready high; literal expectations for the response
    task automatic run_one(input int k, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] xr, input logic xo, input logic xw);
        set_req(k, op, a, b);
        @(negedge i_clk);
        check("d_accept", 64'(o_req_ready), 64'(N'(1) << k));
        step();
        clr_req(k);
        @(negedge i_clk);
        check("d_exec_busy", 64'(o_busy), 64'd1);
        step();
        @(negedge i_clk);
        check("d_rsp_valid",  64'(o_rsp_valid),    64'(N'(1) << k));
        check("d_rsp_result", 64'(o_rsp_result),   64'(xr));
        check("d_rsp_ovf",    64'(o_rsp_overflow), 64'(xo));
        check("d_rsp_we",     64'(o_rsp_write_en), 64'(xw));
        check("d_rsp_id",     64'(o_rsp_id),       64'(k));
        step();
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 4))
            0: return 32'd0;
            1: return 32'h7fffffff;
            2: return 32'h80000000;
            3: return 32'hffffffff;
            default: return $urandom;
        endcase
    endfunction

    initial begin : stim
        int x;
        i_rst = 1'b1; i_req_valid = '0; i_req_opr1 = '0; i_req_opr2 = '0; i_req_op = '0;
        i_rsp_ready = '1;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_busy",   64'(o_busy),       64'd0);
        check("rst_rsp_v",  64'(o_rsp_valid),  64'd0);
        check("rst_alu_a",  64'(o_alu_opr1),   64'd0);
        check("rst_alu_op", 64'(o_alu_op),     64'd0);
        check("rst_result", 64'(o_rsp_result), 64'd0);
        check("rst_id",     64'(o_rsp_id),     64'd0);
        step();

        run_one(0, OP_ADDU, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1);
        run_one(1, OP_ADD, 32'h7fffffff, 32'd1, 32'h80000000, 1'b1, 1'b0);

        // Round robin between requesters 0 and 1, accepts 3 cycles apart
        set_req(0, OP_OR, 32'd1, 32'd2);
        set_req(1, OP_OR, 32'd16, 32'd32);
        for (int j = 0; j < 4; j++) begin
            @(negedge i_clk);
            check("rr_grant", 64'(o_req_ready), 64'(N'(1) << (j % 2)));
            step();
            @(negedge i_clk);
            check("rr_exec_ready", 64'(o_req_ready), 64'd0);
            step();
            @(negedge i_clk);
            check("rr_result", 64'(o_rsp_result), ((j % 2) == 1) ? 64'd48 : 64'd3);
            check("rr_resp_ready", 64'(o_req_ready), 64'd0);
            step();
        end
        i_req_valid = '0;

        // Backpressure: non-owner ready is ignored; no bypass on retire
        i_rsp_ready = 3'b010;
        set_req(0, OP_SLT, 32'hffffffff, 32'd1);
        @(negedge i_clk);
        check("bp_accept", 64'(o_req_ready), 64'd1);
        step();
        clr_req(0);
        set_req(1, OP_ADDU, 32'd100, 32'd23);
        step();
        for (int j = 0; j < 5; j++) begin
            @(negedge i_clk);
            check("bp_hold_valid",  64'(o_rsp_valid),  64'd1);
            check("bp_hold_result", 64'(o_rsp_result), 64'd1);
            check("bp_no_accept",   64'(o_req_ready),  64'd0);
            step();
        end
        i_rsp_ready = 3'b001;
        @(negedge i_clk);
        check("bp_retire_no_bypass", 64'(o_req_ready), 64'd0);
        step();
        @(negedge i_clk);
        check("bp_next_accept", 64'(o_req_ready), 64'd2);
        step();
        clr_req(1);
        i_rsp_ready = '1;
        step();
        @(negedge i_clk);
        check("bp_req1_result", 64'(o_rsp_result), 64'd123);
        step();

        // Reset in EXEC drops the op; pointer returns to 0
        set_req(0, OP_ADDU, 32'd9, 32'd9);
        @(negedge i_clk);
        check("rm_accept", 64'(o_req_ready), 64'd1);
        step();
        clr_req(0);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("rm_ready_exec_rst", 64'(o_req_ready), 64'd0);
        step();
        set_req(0, OP_ADDU, 32'd4, 32'd4);
        set_req(1, OP_ADDU, 32'd6, 32'd6);
        @(negedge i_clk);
        check("rm_ready_in_reset", 64'(o_req_ready), 64'd0);
        check("rm_busy_in_reset",  64'(o_busy),      64'd0);
        step();
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rm_no_rsp",      64'(o_rsp_valid), 64'd0);
        check("rm_grant_first", 64'(o_req_ready), 64'd1);
        step();
        i_req_valid = '0;
        step();
        @(negedge i_clk);
        check("rm_result", 64'(o_rsp_result), 64'd8);
        step();

        run_one(2, OP_MOVZ, 32'd3, 32'd3, 32'd3, 1'b0, 1'b0);
        run_one(1, 5'd31, 32'd1, 32'd2, 32'hcdcdcdcd, 1'b0, 1'b1);

        // Randomized traffic; the model process checks every cycle
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    x = int'($urandom_range(0, 11));
                    i_req_opr1[32*k +: 32] = rnd_word();
                    i_req_opr2[32*k +: 32] = ($urandom_range(0, 3) == 0) ? 32'd0 : rnd_word();
                    i_req_op[5*k +: 5]     = (x == 11) ? 5'd20 : 5'(x);
                    if ($urandom_range(0, 1) == 1) set_req(k, i_req_op[5*k +: 5], i_req_opr1[32*k +: 32], i_req_opr2[32*k +: 32]);
                    else clr_req(k);
                end
            end
            i_rsp_ready = N'($urandom);
            i_rst = ($urandom_range(0, 199) == 0);
            step();
        end
        i_rst = 1'b0;
        i_req_valid = '0;
        i_rsp_ready = '1;
        repeat (5) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
